inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch stage. Owns the PC, issues word requests to instruction memory over a req/ack handshake, and drives if_pc/if_inst into the IF/ID pipeline register.
- Handles flush and branch redirects, including discarding in-flight responses, and requests a pipeline stall while memory is slow.
- Sits between the pipeline controller (stall/flush/new_pc), the ID stage (branch) and the instruction memory port.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
ADDR_W, 32, instruction address / PC width
INST_W, 32, instruction word width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
stall  in  6  controller stall vector; bit0 = IF stage, bit1 = ID stage
flush  in  1  exception/eret flush; redirect to new_pc
new_pc  in  ADDR_W  flush target
branch_flag  in  1  ID-stage taken branch/jump
branch_target  in  ADDR_W  branch destination
inst_req  out  1  memory request valid
inst_addr  out  ADDR_W  request address, stable while inst_req=1 and no ack
inst_ack  in  1  memory response; inst_rdata valid this cycle
inst_rdata  in  INST_W  fetched word
if_pc  out  ADDR_W  PC of instruction presented to IF/ID
if_inst  out  INST_W  instruction presented to IF/ID; ZeroWord = bubble
stallreq_if  out  1  stall request to controller

Behaviour:
- State machine with 4 states: IDLE, FETCH, HOLD, DROP.
- Registers: pc, req_addr, inst_buf, state.
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, req_addr=RESET_PC, inst_buf=0.
- Outputs during reset: inst_req=0, inst_addr=RESET_PC, if_pc=RESET_PC, if_inst=0, stallreq_if=0.
- Redirect priority: flush > branch_flag > sequential.
  - branch_flag is honoured only when stall[1]=0.
  - flush is honoured regardless of stall.
  - In the redirect cycle: pc<=target, if_inst=0.
- Sequential next PC: pc+4, modulo 2^ADDR_W (0xFFFFFFFC+4 = 0).
- IDLE:
  - inst_req=0, if_inst=0.
  - Next cycle → FETCH (redirects apply).
- FETCH (inst_req=1, inst_addr=pc, req_addr<=pc):
  - ack=0: if_inst=0, stallreq_if=1. Redirect → DROP, with req_addr held and inst_addr=req_addr.
  - ack=1, stall[0]=0, no redirect: combinational pass-through, if_pc=pc, if_inst=inst_rdata. pc<=pc+4, stay FETCH. The next request is issued the following cycle (back-to-back, 1 inst/cycle at zero-wait memory).
  - ack=1, stall[0]=1: inst_buf<=inst_rdata → HOLD; if_inst=0.
  - ack=1 with redirect: data discarded, → FETCH at the target.
- HOLD:
  - inst_req=0, if_pc=pc, if_inst=inst_buf, stallreq_if=0.
  - stall[0]=0: pc<=pc+4 → FETCH.
  - Redirect: buffer dropped → FETCH.
- DROP:
  - inst_req=1, inst_addr=req_addr (a request, once issued, is never withdrawn); if_inst=0, stallreq_if=1.
  - ack=1: data discarded → FETCH at pc.
  - A further redirect updates pc and stays in DROP.
- Handshake rules:
  - inst_addr and inst_req are stable from the assertion of inst_req until the ack cycle.
  - inst_ack outside an outstanding request is ignored.
- if_pc equals pc in all states except DROP, where it is pc with if_inst=0.
- Reset mid-request abandons the transaction; memory must tolerate this.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Defined:
  - Adds output port if_excp_adel (1 bit).
  - In FETCH with pc[1:0]!=0: no request is issued, if_inst=0, if_excp_adel=1, stallreq_if=0.
  - pc is held until a flush redirects it.
  - if_excp_adel resets to 0.
- Undefined:
  - Port absent.
  - pc[1:0] is passed unchecked to inst_addr.

Decomposition:
- Shared constants in define.v: ZeroWord, Stop/NoStop, InstAddrBus/InstBus.
- Add RstnEnable (1'b0) for the active-low reset.
- FSM state encodings are localparams inside the module.
- No sub-module; a single module of roughly 150–200 lines.

Test Plan:
- Reset with RESET_PC=0, zero-wait memory (ack same cycle) → inst_addr=0,4,8 on consecutive cycles; if_inst tracks rdata; stallreq_if=0.
- Memory ack delayed 3 cycles at pc=0x10 → inst_addr=0x10 held for 4 cycles, stallreq_if=1 for 3 cycles, if_inst=0 until ack, then pc advances to 0x14.
- stall[0]=1 on ack of 0x20 (data 0xDEADBEEF) for 2 cycles → HOLD, no inst_req, if_inst=0xDEADBEEF after release, next request 0x24.
- flush with new_pc=0x180 while request 0x40 is outstanding (ack 2 cycles later) → inst_addr stays 0x40 until ack, data discarded, next request 0x180.
- branch_flag=1, branch_target=0x100 with stall[1]=0 → next request 0x100. Same pulse with stall[1]=1 → ignored. flush and branch in the same cycle → new_pc wins.
- pc=0xFFFFFFFC with zero-wait memory → next inst_addr=0x00000000. With IF_ALIGN_CHECK_EN and a redirect to 0x102 → if_excp_adel=1, inst_req=0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants and FSM state type for the instruction-fetch stage.
package inst_fetch_pkg;

  // Default bus widths
  localparam int unsigned InstAddrBusW = 32;
  localparam int unsigned InstBusW     = 32;

  // A zero instruction word is a pipeline bubble
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Stall request / stall vector bit levels
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Reset is asserted when rst is low
  localparam logic RstnEnable = 1'b0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2,
    StDrop  = 2'd3
  } if_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack port,
// buffers a word while IF is stalled and discards responses made stale by
// flush/branch redirects.
// Optional macro IF_ALIGN_CHECK_EN adds if_excp_adel and blocks fetches from
// a misaligned PC.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = InstAddrBusW,
  parameter int unsigned       INST_W   = InstBusW,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ack,
  input  logic [INST_W-1:0] inst_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
`ifdef IF_ALIGN_CHECK_EN
  output logic              if_excp_adel,
`endif
  output logic              stallreq_if
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [INST_W-1:0] inst_buf_q, inst_buf_d;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] pc_seq;
  logic              misaligned;

  // Only the IF and ID bits of the stall vector matter here
  logic unused_stall;
  assign unused_stall = ^stall[5:2];

  assign pc_seq = pc_q + ADDR_W'(4);
  assign if_pc  = pc_q;

`ifdef IF_ALIGN_CHECK_EN
  assign misaligned   = (pc_q[1:0] != 2'b00);
  assign if_excp_adel = (state_q == StFetch) && misaligned;
`else
  assign misaligned   = 1'b0;
`endif

  // Redirect selection: flush always wins; branch only when ID is not stalled
  always_comb begin
    redirect    = flush | (branch_flag & (stall[1] == NoStop));
    redirect_pc = flush ? new_pc : branch_target;
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    inst_buf_d  = inst_buf_q;
    inst_req    = 1'b0;
    inst_addr   = pc_q;
    if_inst     = INST_W'(ZeroWord);
    stallreq_if = NoStop;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        if (redirect) pc_d = redirect_pc;
      end

      StFetch: begin
        if (misaligned) begin
          // No request from a bad PC; wait for the exception flush
          if (flush) pc_d = new_pc;
        end else begin
          inst_req   = 1'b1;
          req_addr_d = pc_q;
          if (!inst_ack) begin
            stallreq_if = Stop;
            // Request already issued: must wait out its ack in DROP
            if (redirect) begin
              pc_d    = redirect_pc;
              state_d = StDrop;
            end
          end else if (redirect) begin
            pc_d = redirect_pc;
          end else if (stall[0] == Stop) begin
            inst_buf_d = inst_rdata;
            state_d    = StHold;
          end else begin
            if_inst = inst_rdata;
            pc_d    = pc_seq;
          end
        end
      end

      StHold: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = StFetch;
        end else begin
          if_inst = inst_buf_q;
          if (stall[0] == NoStop) begin
            pc_d    = pc_seq;
            state_d = StFetch;
          end
        end
      end

      StDrop: begin
        inst_req    = 1'b1;
        inst_addr   = req_addr_q;
        stallreq_if = Stop;
        if (redirect) pc_d = redirect_pc;
        if (inst_ack) state_d = StFetch;
      end

      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstnEnable) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      inst_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inst_buf_q <= inst_buf_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a transaction-level reference model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack = 1'b0;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;
`ifdef IF_ALIGN_CHECK_EN
  logic        if_excp_adel;
`endif

  // Memory: word content is address ^ 0x12340000 unless overridden
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;
  assign inst_rdata = ovr_en ? ovr_val : (inst_addr ^ 32'h1234_0000);

  int tests = 0;
  int fails = 0;

  inst_fetch #(
    .ADDR_W  (32),
    .INST_W  (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_ack     (inst_ack),
    .inst_rdata   (inst_rdata),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
`ifdef IF_ALIGN_CHECK_EN
    .if_excp_adel (if_excp_adel),
`endif
    .stallreq_if  (stallreq_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Reference model: abstract fetch bookkeeping (started / buffered word /
  // stale outstanding request), evaluated once per cycle before the edge.
  logic [31:0] m_pc, m_buf, m_dead_addr;
  bit          m_started, m_buf_v, m_dead;

  initial begin
    logic        redir, e_req, e_sr, e_adel, mis;
    logic [31:0] tgt, e_addr, e_inst, n_pc, rd;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_pc = 32'h0; m_started = 0; m_buf_v = 0; m_dead = 0; m_buf = '0;
        chk("m_rst_req", inst_req, 0);
        chk("m_rst_addr", inst_addr, 32'h0);
        chk("m_rst_if_pc", if_pc, 32'h0);
        chk("m_rst_if_inst", if_inst, 32'h0);
        chk("m_rst_stallreq", stallreq_if, 0);
`ifdef IF_ALIGN_CHECK_EN
        chk("m_rst_adel", if_excp_adel, 0);
`endif
      end else begin
        redir  = flush || (branch_flag && !stall[1]);
        tgt    = flush ? new_pc : branch_target;
        e_req  = 0; e_addr = m_pc; e_inst = 0; e_sr = 0; e_adel = 0;
        n_pc   = m_pc;
        mis    = 0;
`ifdef IF_ALIGN_CHECK_EN
        mis    = (m_pc[1:0] != 2'b00);
`endif
        if (!m_started) begin
          m_started = 1;
          if (redir) n_pc = tgt;
        end else if (m_buf_v) begin
          if (redir) begin
            n_pc = tgt; m_buf_v = 0;
          end else begin
            e_inst = m_buf;
            if (!stall[0]) begin n_pc = m_pc + 32'd4; m_buf_v = 0; end
          end
        end else if (m_dead) begin
          e_req = 1; e_addr = m_dead_addr; e_sr = 1;
          if (redir) n_pc = tgt;
          if (inst_ack) m_dead = 0;
        end else if (mis) begin
          e_adel = 1;
          if (flush) n_pc = new_pc;
        end else begin
          e_req = 1;
          rd = ovr_en ? ovr_val : (m_pc ^ 32'h1234_0000);
          if (!inst_ack) begin
            e_sr = 1;
            if (redir) begin m_dead = 1; m_dead_addr = m_pc; n_pc = tgt; end
          end else if (redir) begin
            n_pc = tgt;
          end else if (stall[0]) begin
            m_buf = rd; m_buf_v = 1;
          end else begin
            e_inst = rd; n_pc = m_pc + 32'd4;
          end
        end
        chk("m_req", inst_req, e_req);
        if (e_req) chk("m_addr", inst_addr, e_addr);
        chk("m_if_pc", if_pc, m_pc);
        chk("m_if_inst", if_inst, e_inst);
        chk("m_stallreq", stallreq_if, e_sr);
`ifdef IF_ALIGN_CHECK_EN
        chk("m_adel", if_excp_adel, e_adel);
`else
        if (e_adel) chk("m_adel_unexpected", 1, 0);
`endif
        m_pc = n_pc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Directed stimulus with literal expectations
  initial begin
    neg();
    chk("rst_req", inst_req, 0);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    cyc();
    rst = 1'b1;
    inst_ack = 1'b1;

    // Zero-wait sequential fetch
    neg(); chk("idle_req", inst_req, 0); cyc();
    neg(); chk("zw_addr0", inst_addr, 32'h0); chk("zw_inst0", if_inst, 32'h1234_0000); cyc();
    neg(); chk("zw_addr4", inst_addr, 32'h4); cyc();
    neg(); chk("zw_addr8", inst_addr, 32'h8); chk("zw_inst8", if_inst, 32'h1234_0008);
    chk("zw_stallreq", stallreq_if, 0); cyc();
    neg(); cyc();

    // Ack delayed 3 cycles at 0x10
    inst_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      neg(); chk("slow_addr", inst_addr, 32'h10); chk("slow_stallreq", stallreq_if, 1);
      chk("slow_inst", if_inst, 32'h0); cyc();
    end
    inst_ack = 1'b1;
    neg(); chk("slow_ack_addr", inst_addr, 32'h10); chk("slow_ack_inst", if_inst, 32'h1234_0010);
    chk("slow_ack_stallreq", stallreq_if, 0); cyc();
    neg(); chk("slow_next", inst_addr, 32'h14); cyc();
    neg(); cyc();
    neg(); cyc();

    // IF stall on ack of 0x20 -> HOLD
    ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF; stall = 6'b000001;
    neg(); chk("hold_addr", inst_addr, 32'h20); chk("hold_in_inst", if_inst, 32'h0); cyc();
    ovr_en = 1'b0;
    neg(); chk("hold_req", inst_req, 0); cyc();
    stall = 6'b000000;
    neg(); chk("hold_rel_inst", if_inst, 32'hDEAD_BEEF); chk("hold_rel_req", inst_req, 0); cyc();
    neg(); chk("hold_next", inst_addr, 32'h24); chk("hold_next_req", inst_req, 1); cyc();
    repeat (6) cyc();

    // Flush while 0x40 outstanding
    inst_ack = 1'b0; flush = 1'b1; new_pc = 32'h180;
    neg(); chk("fl_addr0", inst_addr, 32'h40); cyc();
    flush = 1'b0;
    neg(); chk("fl_addr1", inst_addr, 32'h40); chk("fl_if_pc", if_pc, 32'h180);
    chk("fl_stallreq", stallreq_if, 1); cyc();
    inst_ack = 1'b1;
    neg(); chk("fl_addr2", inst_addr, 32'h40); chk("fl_discard", if_inst, 32'h0); cyc();
    neg(); chk("fl_target", inst_addr, 32'h180); cyc();

    // Branch taken, branch ignored under ID stall, flush beats branch
    branch_flag = 1'b1; branch_target = 32'h100;
    neg(); chk("br_bubble", if_inst, 32'h0); cyc();
    branch_flag = 1'b0;
    neg(); chk("br_target", inst_addr, 32'h100); cyc();
    branch_flag = 1'b1; branch_target = 32'h200; stall = 6'b000010;
    neg(); chk("br_stalled_inst", if_inst, 32'h1234_0104); cyc();
    branch_flag = 1'b0; stall = 6'b000000;
    neg(); chk("br_stalled_seq", inst_addr, 32'h108); cyc();
    flush = 1'b1; new_pc = 32'h300; branch_flag = 1'b1; branch_target = 32'h200;
    neg(); cyc();
    flush = 1'b0; branch_flag = 1'b0;
    neg(); chk("fl_over_br", inst_addr, 32'h300); cyc();

    // PC wrap
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    neg(); cyc();
    flush = 1'b0;
    neg(); chk("wrap_addr", inst_addr, 32'hFFFF_FFFC); chk("wrap_inst", if_inst, 32'hEDCB_FFFC); cyc();
    neg(); chk("wrap_zero", inst_addr, 32'h0); cyc();

    // Redirects while a dropped request is outstanding
    inst_ack = 1'b0; branch_flag = 1'b1; branch_target = 32'h500;
    neg(); chk("drop_addr0", inst_addr, 32'h4); cyc();
    branch_target = 32'h600;
    neg(); chk("drop_addr1", inst_addr, 32'h4); chk("drop_pc1", if_pc, 32'h500); cyc();
    branch_flag = 1'b0; inst_ack = 1'b1;
    neg(); chk("drop_pc2", if_pc, 32'h600); chk("drop_addr2", inst_addr, 32'h4); cyc();
    neg(); chk("drop_resume", inst_addr, 32'h600); chk("drop_resume_inst", if_inst, 32'h1234_0600); cyc();

    // Reset in the middle of an outstanding request
    inst_ack = 1'b0;
    neg(); cyc();
    rst = 1'b0;
    #1;
    chk("midrst_req", inst_req, 0); chk("midrst_addr", inst_addr, 32'h0);
    neg(); cyc();
    rst = 1'b1; inst_ack = 1'b1;
    neg(); chk("midrst_idle", inst_req, 0); cyc();
    neg(); chk("midrst_fetch", inst_addr, 32'h0); cyc();

`ifdef IF_ALIGN_CHECK_EN
    // Misaligned PC: no request, exception flagged, only flush escapes
    flush = 1'b1; new_pc = 32'h102;
    neg(); cyc();
    flush = 1'b0;
    neg(); chk("adel_req", inst_req, 0); chk("adel_flag", if_excp_adel, 1);
    chk("adel_stallreq", stallreq_if, 0); cyc();
    branch_flag = 1'b1; branch_target = 32'h100;
    neg(); cyc();
    branch_flag = 1'b0;
    neg(); chk("adel_hold_pc", if_pc, 32'h102); cyc();
    flush = 1'b1; new_pc = 32'h0;
    neg(); cyc();
    flush = 1'b0;
    neg(); chk("adel_recover", inst_addr, 32'h0); chk("adel_clear", if_excp_adel, 0); cyc();
`endif

    repeat (2) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
